// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the load/store unit: FSM encoding, default lowest
// implemented RAM address and event-counter width.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    localparam int ADDR_MIN_DEF = 7;
    localparam int CNT_W        = 8;

endpackage

// File: rtl/sat_counter.sv
// Event counter that increments when enabled and sticks at its maximum value.
module sat_counter
    import cpu_mem_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: step by one unless already at all-ones.
    always_comb begin
        count_d = count_q;
        if (en && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between a core request/response port and
// a data RAM with a synchronous write port and a combinational read port.
// Addresses below ADDR_MIN fault without touching the RAM.
module load_store_unit
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int ADDR_MIN = ADDR_MIN_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_adrs,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_fault,
    output logic              ram_en,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_adrs_a,
    output logic [DATA_W-1:0] ram_data_in,
    output logic [ADDR_W-1:0] ram_adrs_b,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic [CNT_W-1:0]  cnt_load,
    output logic [CNT_W-1:0]  cnt_store,
    output logic [CNT_W-1:0]  cnt_fault
);

    localparam logic [ADDR_W-1:0] ADDR_MIN_L = ADDR_W'(ADDR_MIN);

    lsu_state_e        state_q, state_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] adrs_q, adrs_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              fault_q, fault_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rsp_hs;

    // Next-state, request capture and RAM strobes.
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        adrs_d    = adrs_q;
        wdata_d   = wdata_q;
        fault_d   = fault_q;
        rdata_d   = rdata_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        ram_en    = 1'b0;
        ram_wr    = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    wr_d    = req_wr;
                    adrs_d  = req_adrs;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    if (req_adrs < ADDR_MIN_L) begin
                        fault_d = 1'b1;
                        state_d = RESP;
                    end else begin
                        fault_d = 1'b0;
                        state_d = req_wr ? WRITE : READ;
                    end
                end
            end
            WRITE: begin
                ram_en  = 1'b1;
                ram_wr  = 1'b1;
                state_d = RESP;
            end
            READ: begin
                rdata_d = ram_data_out;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched-request registers; reset drops any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            adrs_q  <= '0;
            wdata_q <= '0;
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            adrs_q  <= adrs_d;
            wdata_q <= wdata_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
        end
    end

    // Both RAM ports always see the latched address, so the read port never
    // follows the raw request bus.
    assign ram_adrs_a  = adrs_q;
    assign ram_adrs_b  = adrs_q;
    assign ram_data_in = wdata_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_fault   = fault_q;

    assign rsp_hs = (state_q == RESP) && rsp_ready;

    sat_counter #(.W(CNT_W)) u_cnt_load (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rsp_hs && !fault_q && !wr_q),
        .count (cnt_load)
    );

    sat_counter #(.W(CNT_W)) u_cnt_store (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rsp_hs && !fault_q && wr_q),
        .count (cnt_store)
    );

    sat_counter #(.W(CNT_W)) u_cnt_fault (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rsp_hs && fault_q),
        .count (cnt_fault)
    );

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural data RAM.
module tb_load_store_unit;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid, req_ready, req_wr;
    logic [AW-1:0] req_adrs;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready, rsp_fault;
    logic [DW-1:0] rsp_rdata;
    logic          ram_en, ram_wr;
    logic [AW-1:0] ram_adrs_a, ram_adrs_b;
    logic [DW-1:0] ram_data_in, ram_data_out;
    logic [7:0]    cnt_load, cnt_store, cnt_fault;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    int            total = 0;
    int            bad = 0;
    int            wr_pulses = 0;
    int            en_cycles = 0;
    logic [AW-1:0] last_wa;
    logic [DW-1:0] last_wd;
    int            lat;
    int            wp;
    int            ec;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(AW), .DATA_W(DW), .ADDR_MIN(7)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_adrs     (req_adrs),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_fault    (rsp_fault),
        .ram_en       (ram_en),
        .ram_wr       (ram_wr),
        .ram_adrs_a   (ram_adrs_a),
        .ram_data_in  (ram_data_in),
        .ram_adrs_b   (ram_adrs_b),
        .ram_data_out (ram_data_out),
        .cnt_load     (cnt_load),
        .cnt_store    (cnt_store),
        .cnt_fault    (cnt_fault)
    );

    // Behavioural RAM: contents i ^ 0x55 at reset, write on clock edge.
    assign ram_data_out = mem[ram_adrs_b];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= 8'(i) ^ 8'h55;
        end else begin
            if (ram_en) en_cycles++;
            if (ram_en && ram_wr) begin
                mem[ram_adrs_a] <= ram_data_in;
                wr_pulses++;
                last_wa = ram_adrs_a;
                last_wd = ram_data_in;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one request, wait for the accept edge, then count edges until
    // rsp_valid (accept edge counts as 1; bounded).
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int l);
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = wr;
        req_adrs  = a;
        req_wdata = d;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        l = 1;
        while (rsp_valid !== 1'b1 && l < 8) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_adrs  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        check("rst_ram_en", 32'({ram_en, ram_wr}), 32'd0);
        check("rst_adrs", 32'({ram_adrs_a, ram_adrs_b, ram_data_in}), 32'd0);
        check("rst_cnts", 32'({cnt_load, cnt_store, cnt_fault}), 32'd0);

        // Store 0xA5 to 10
        issue(1'b1, 5'd10, 8'hA5, lat);
        check("st10_lat", 32'(lat), 32'd2);
        check("st10_fault", 32'(rsp_fault), 32'd0);
        check("st10_rdata", 32'(rsp_rdata), 32'd0);
        check("st10_pulses", 32'(wr_pulses), 32'd1);
        check("st10_wa", 32'(last_wa), 32'd10);
        check("st10_wd", 32'(last_wd), 32'hA5);
        handshake();
        check("st10_cnt_store", 32'(cnt_store), 32'd1);

        // Load 10 returns stored value
        issue(1'b0, 5'd10, 8'h00, lat);
        check("ld10_lat", 32'(lat), 32'd2);
        check("ld10_rdata", 32'(rsp_rdata), 32'hA5);
        check("ld10_fault", 32'(rsp_fault), 32'd0);
        handshake();
        check("ld10_cnt_load", 32'(cnt_load), 32'd1);

        // Faulting load from 3
        ec = en_cycles;
        issue(1'b0, 5'd3, 8'h00, lat);
        check("ld3_lat", 32'(lat), 32'd1);
        check("ld3_fault", 32'(rsp_fault), 32'd1);
        check("ld3_rdata", 32'(rsp_rdata), 32'd0);
        handshake();
        check("ld3_ram_en", 32'(en_cycles), 32'(ec));
        check("ld3_cnt_fault", 32'(cnt_fault), 32'd1);
        check("ld3_cnt_load", 32'(cnt_load), 32'd1);

        // Faulting store from 6 never strobes the RAM
        ec = en_cycles;
        issue(1'b1, 5'd6, 8'hEE, lat);
        check("st6_fault", 32'(rsp_fault), 32'd1);
        handshake();
        check("st6_ram_en", 32'(en_cycles), 32'(ec));
        check("st6_cnts", 32'({cnt_store, cnt_fault}), 32'h0102);

        // Boundary addresses
        issue(1'b1, 5'd31, 8'h3C, lat);
        check("st31_fault", 32'(rsp_fault), 32'd0);
        check("st31_wa", 32'(last_wa), 32'd31);
        handshake();
        issue(1'b0, 5'd7, 8'h00, lat);
        check("ld7_fault", 32'(rsp_fault), 32'd0);
        check("ld7_rdata", 32'(rsp_rdata), 32'h52);
        handshake();

        // Back-pressure in RESP with a competing request
        issue(1'b0, 5'd31, 8'h00, lat);
        check("ld31_rdata", 32'(rsp_rdata), 32'h3C);
        wp = wr_pulses;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_wr    = 1'b1;
            req_adrs  = 5'd12;
            req_wdata = 8'hFF;
            @(posedge clk);
            #1;
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", 32'(rsp_rdata), 32'h3C);
            check("hold_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        handshake();
        repeat (2) @(posedge clk);
        #1;
        check("hold_no_write", 32'(wr_pulses), 32'(wp));
        check("hold_idle", 32'(rsp_valid), 32'd0);
        check("hold_cnts", 32'({cnt_load, cnt_store, cnt_fault}), 32'h030202);

        // Reset during WRITE
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_adrs  = 5'd20;
        req_wdata = 8'h77;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("wr_state_ram_wr", 32'({ram_en, ram_wr}), 32'd3);
        wp = wr_pulses;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_ram_wr", 32'({ram_en, ram_wr}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'd1);
        check("post_rst_valid", 32'(rsp_valid), 32'd0);
        check("post_rst_cnts", 32'({cnt_load, cnt_store, cnt_fault}), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        check("post_rst_no_wr", 32'(wr_pulses), 32'(wp));

        // Store counter saturation
        for (int i = 0; i < 260; i++) begin
            issue(1'b1, 5'(8 + (i % 24)), 8'(i), lat);
            handshake();
            if (i == 253) check("sat_254", 32'(cnt_store), 32'd254);
        end
        check("sat_store", 32'(cnt_store), 32'd255);
        check("sat_load", 32'(cnt_load), 32'd0);
        check("sat_fault", 32'(cnt_fault), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
